// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_2r1w register file.
// The initialisation sweep's FSM states and the address-width calculation.
package regfile_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_t;

  // DEPTH is a power of two >= 2, so this is never below 1.
  function automatic int calc_aw(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Init sweep sequencer for regfile_2r1w: walks every address once, writing
// INIT_VAL, and raises busy during the walk and a one-cycle done at the end.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter int              DEPTH    = 8,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int             AW       = calc_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             init_req,
  output logic             busy,
  output logic             done,
  output logic             sweep_we,
  output logic [AW-1:0]    sweep_addr,
  output logic [WIDTH-1:0] sweep_data
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  sweep_state_t    state_reg, state_next;
  logic [AW-1:0]   idx_reg, idx_next;
  logic            done_reg, done_next;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      done_reg  <= done_next;
    end
  end

  // init_req is only looked at in IDLE, so holding it high re-arms a sweep
  // on the cycle right after done.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (init_req) begin
          state_next = SWEEP;
          idx_next   = '0;
        end
      end
      SWEEP: begin
        idx_next = idx_reg + AW'(1);
        if (idx_reg == LAST_IDX) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy       = (state_reg == SWEEP);
  assign done       = done_reg;
  assign sweep_we   = busy;
  assign sweep_addr = idx_reg;
  assign sweep_data = INIT_VAL;

endmodule

// File: rtl/regfile_2r1w.sv
// One-write, two-registered-read register file with an init sweep.
// Define REGFILE_BYPASS_EN for write-first forwarding on same-edge collisions.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter int              DEPTH    = 8,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int             AW       = calc_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb,
  input  logic             init_req,
  output logic             busy,
  output logic             done
);

  logic             sweep_we;
  logic [AW-1:0]    sweep_addr;
  logic [WIDTH-1:0] sweep_data;

  regfile_init_seq #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .INIT_VAL (INIT_VAL)
  ) u_init_seq (
    .clk        (clk),
    .clr        (clr),
    .init_req   (init_req),
    .busy       (busy),
    .done       (done),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr),
    .sweep_data (sweep_data)
  );

  // The sweep owns the write port while busy; user writes are dropped then.
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  assign wr_en   = sweep_we | (we & ~busy);
  assign wr_addr = sweep_we ? sweep_addr : waddr;
  assign wr_data = sweep_we ? sweep_data : wdata;

  // Reset clears to zero rather than INIT_VAL, so this is a flop array.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Port 0 is A, port 1 is B; each does its own collision compare.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] q_reg;

    assign addr = (gi == 0) ? ra_addr : rb_addr;

`ifdef REGFILE_BYPASS_EN
    assign rd_val = (wr_en && (wr_addr == addr)) ? wr_data : mem[addr];
`else
    assign rd_val = mem[addr];
`endif

    always_ff @(posedge clk or posedge clr) begin
      if (clr)     q_reg <= '0;
      else if (re) q_reg <= rd_val;
    end
  end

  assign qa = g_port[0].q_reg;
  assign qb = g_port[1].q_reg;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: an 8x8 instance (INIT_VAL=0xFF) checked
// against an array model, plus a 32x32 instance for the scaling case.
module tb_regfile_2r1w;

  localparam int          D   = 8;
  localparam logic [7:0]  IV  = 8'hFF;
  localparam int          BD  = 32;
  localparam logic [31:0] BIV = 32'hC0FFEE42;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic       clk, clr;
  logic       we, re, init_req;
  logic [2:0] waddr, ra_addr, rb_addr;
  logic [7:0] wdata, qa, qb;
  logic       busy, done;

  logic        b_we, b_re, b_init_req;
  logic [4:0]  b_waddr, b_ra_addr, b_rb_addr;
  logic [31:0] b_wdata, b_qa, b_qb;
  logic        b_busy, b_done;

  regfile_2r1w #(.WIDTH(8), .DEPTH(D), .INIT_VAL(IV)) u_dut (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .qa(qa), .qb(qb),
    .init_req(init_req), .busy(busy), .done(done)
  );

  regfile_2r1w #(.WIDTH(32), .DEPTH(BD), .INIT_VAL(BIV)) u_big (
    .clk(clk), .clr(clr), .we(b_we), .waddr(b_waddr), .wdata(b_wdata), .re(b_re),
    .ra_addr(b_ra_addr), .rb_addr(b_rb_addr), .qa(b_qa), .qb(b_qb),
    .init_req(b_init_req), .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the 8x8 instance.
  logic [7:0] model [D];
  bit         m_busy;
  int         m_pos;
  logic [7:0] exp_qa, exp_qb;
  logic       exp_busy, exp_done;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic model_reset();
    for (int i = 0; i < D; i++) model[i] = 8'h00;
    m_busy = 0; m_pos = 0;
    exp_qa = 8'h00; exp_qb = 8'h00; exp_busy = 1'b0; exp_done = 1'b0;
  endtask

  task automatic model_edge();
    bit         wv;
    int         wa;
    logic [7:0] wd;
    if (clr) return;
    wv = 0; wa = 0; wd = 8'h00;
    if (m_busy) begin
      wv = 1; wa = m_pos; wd = IV;
    end else if (we) begin
      wv = 1; wa = int'(waddr); wd = wdata;
    end
    if (re) begin
      exp_qa = (BYPASS && wv && wa == int'(ra_addr)) ? wd : model[ra_addr];
      exp_qb = (BYPASS && wv && wa == int'(rb_addr)) ? wd : model[rb_addr];
    end
    if (wv) model[wa] = wd;
    exp_done = 1'b0;
    if (m_busy) begin
      m_pos++;
      if (m_pos == D) begin
        m_busy = 0;
        exp_done = 1'b1;
      end
    end else if (init_req) begin
      m_busy = 1;
      m_pos = 0;
    end
    exp_busy = m_busy;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    we = 0; re = 0; init_req = 0; waddr = 0; wdata = 0; ra_addr = 0; rb_addr = 0;
    b_we = 0; b_re = 0; b_init_req = 0; b_waddr = 0; b_wdata = 0; b_ra_addr = 0; b_rb_addr = 0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (qa !== 8'h00 || qb !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_state: qa=%h qb=%h busy=%b done=%b, expected all zero", qa, qb, busy, done);
    else n_pass++;
    clr = 1'b0;
    for (int i = 0; i < D; i++) begin
      we = 1; waddr = 3'(i); wdata = 8'hA5;
      tick();
    end
    we = 0; re = 1; ra_addr = 3; rb_addr = 6;
    tick();
    n_checks++;
    if (qa !== exp_qa || qb !== exp_qb)
      $display("FAIL reset_prefill: qa=%h qb=%h expected %h %h", qa, qb, exp_qa, exp_qb);
    else n_pass++;
    re = 0;
    #3 clr = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (qa !== 8'h00 || qb !== 8'h00 || busy !== 1'b0)
      $display("FAIL reset_async: qa=%h qb=%h busy=%b expected 00 00 0", qa, qb, busy);
    else n_pass++;
    #2 clr = 1'b0;
    for (int i = 0; i < D; i++) begin
      re = 1; ra_addr = 3'(i); rb_addr = 3'(D - 1 - i);
      tick();
      n_checks++;
      if (qa !== 8'h00 || qb !== 8'h00)
        $display("FAIL reset_readback[%0d]: qa=%h qb=%h expected 00 00", i, qa, qb);
      else n_pass++;
    end
    re = 0;
    $display("test_reset: complete");
  endtask

  task automatic test_dual_read();
    we = 1; waddr = 3; wdata = 8'h3C; tick();
    we = 1; waddr = 5; wdata = 8'h5A; tick();
    we = 0; re = 1; ra_addr = 3; rb_addr = 5;
    tick();
    n_checks++;
    if (qa !== 8'h3C || qb !== 8'h5A || qa !== exp_qa || qb !== exp_qb)
      $display("FAIL dual_read: qa=%h qb=%h expected 3c 5a", qa, qb);
    else n_pass++;
    re = 0; ra_addr = 1; rb_addr = 2;
    repeat (2) tick();
    n_checks++;
    if (qa !== 8'h3C || qb !== 8'h5A)
      $display("FAIL dual_read_hold: qa=%h qb=%h expected 3c 5a", qa, qb);
    else n_pass++;
    $display("test_dual_read: complete");
  endtask

  task automatic test_collision();
    logic [7:0] want;
    we = 1; waddr = 2; wdata = 8'h11; tick();
    we = 1; waddr = 2; wdata = 8'h22; re = 1; ra_addr = 2; rb_addr = 5;
    tick();
    want = BYPASS ? 8'h22 : 8'h11;
    n_checks++;
    if (qa !== want || qa !== exp_qa || qb !== exp_qb)
      $display("FAIL collision_same_edge: qa=%h qb=%h expected %h %h", qa, qb, want, exp_qb);
    else n_pass++;
    we = 0;
    tick();
    n_checks++;
    if (qa !== 8'h22)
      $display("FAIL collision_next_read: qa=%h expected 22", qa);
    else n_pass++;
    re = 0;
    $display("test_collision: complete");
  endtask

  task automatic test_sweep();
    int busy_cycles, done_cnt, done_at;
    init_req = 1; re = 0;
    tick();
    init_req = 0;
    busy_cycles = 0; done_cnt = 0; done_at = -1;
    for (int c = 0; c < 12; c++) begin
      n_checks++;
      if (busy !== exp_busy || done !== exp_done)
        $display("FAIL sweep_cycle[%0d]: busy=%b done=%b expected %b %b", c, busy, done, exp_busy, exp_done);
      else n_pass++;
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) begin done_cnt++; done_at = c; end
      if (c == 3) begin we = 1; waddr = 4; wdata = 8'h77; end
      else we = 0;
      tick();
    end
    n_checks++;
    if (busy_cycles != D || done_cnt != 1 || done_at != D)
      $display("FAIL sweep_handshake: busy_cycles=%0d done_count=%0d done_at=%0d expected %0d 1 %0d",
               busy_cycles, done_cnt, done_at, D, D);
    else n_pass++;
    for (int i = 0; i < D; i++) begin
      re = 1; ra_addr = 3'(i); rb_addr = 3'(D - 1 - i);
      tick();
      n_checks++;
      if (qa !== IV || qb !== IV)
        $display("FAIL sweep_readback[%0d]: qa=%h qb=%h expected %h", i, qa, qb, IV);
      else n_pass++;
    end
    re = 0;
    $display("test_sweep: complete");
  endtask

  task automatic test_back_to_back();
    init_req = 1;
    tick();
    for (int c = 0; c < 24; c++) begin
      if (c == 10) init_req = 0;
      n_checks++;
      if (busy !== exp_busy || done !== exp_done)
        $display("FAIL back_to_back[%0d]: busy=%b done=%b expected %b %b", c, busy, done, exp_busy, exp_done);
      else n_pass++;
      tick();
    end
    $display("test_back_to_back: complete");
  endtask

  task automatic test_abort();
    int done_seen;
    for (int i = 0; i < D; i++) begin
      we = 1; waddr = 3'(i); wdata = 8'(i * 16 + 1);
      tick();
    end
    we = 0; init_req = 1;
    tick();
    init_req = 0;
    repeat (3) tick();
    #2 clr = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_state: busy=%b done=%b expected 0 0", busy, done);
    else n_pass++;
    #1 clr = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    n_checks++;
    if (done_seen != 0)
      $display("FAIL abort_no_done: %0d cycles with done/busy high, expected 0", done_seen);
    else n_pass++;
    for (int i = 0; i < D; i++) begin
      re = 1; ra_addr = 3'(i); rb_addr = 3'(D - 1 - i);
      tick();
      n_checks++;
      if (qa !== 8'h00 || qb !== 8'h00)
        $display("FAIL abort_readback[%0d]: qa=%h qb=%h expected 00 00", i, qa, qb);
      else n_pass++;
    end
    re = 0;
    $display("test_abort: complete");
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      we       = 1'($urandom_range(0, 1));
      waddr    = 3'($urandom);
      wdata    = 8'($urandom);
      re       = ($urandom_range(0, 3) != 0);
      ra_addr  = 3'($urandom);
      rb_addr  = ($urandom_range(0, 3) == 0) ? ra_addr : 3'($urandom);
      init_req = ($urandom_range(0, 39) == 0);
      tick();
      n_checks++;
      if (qa !== exp_qa || qb !== exp_qb || busy !== exp_busy || done !== exp_done)
        $display("FAIL random[%0d]: qa=%h qb=%h busy=%b done=%b expected %h %h %b %b",
                 c, qa, qb, busy, done, exp_qa, exp_qb, exp_busy, exp_done);
      else n_pass++;
    end
    idle_inputs();
    repeat (D + 2) tick();
    $display("test_random: complete");
  endtask

  task automatic test_scale();
    logic [31:0] bmodel [BD];
    int busy_cycles;
    int errs;
    for (int i = 0; i < BD; i++) begin
      bmodel[i] = $urandom;
      b_we = 1; b_waddr = 5'(i); b_wdata = bmodel[i];
      tick();
    end
    b_we = 0;
    errs = 0;
    for (int i = 0; i < BD; i++) begin
      b_re = 1; b_ra_addr = 5'(i); b_rb_addr = 5'(BD - 1 - i);
      tick();
      n_checks++;
      if (b_qa !== bmodel[i] || b_qb !== bmodel[BD - 1 - i])
        $display("FAIL scale_readback[%0d]: qa=%h qb=%h expected %h %h",
                 i, b_qa, b_qb, bmodel[i], bmodel[BD - 1 - i]);
      else n_pass++;
    end
    b_re = 0; b_init_req = 1;
    tick();
    b_init_req = 0;
    busy_cycles = 0;
    for (int c = 0; c < 60 && b_busy === 1'b1; c++) begin
      busy_cycles++;
      tick();
    end
    n_checks++;
    if (busy_cycles != BD || b_done !== 1'b1)
      $display("FAIL scale_sweep: busy_cycles=%0d done=%b expected %0d 1", busy_cycles, b_done, BD);
    else n_pass++;
    b_re = 1; b_ra_addr = 0; b_rb_addr = 5'(BD - 1);
    tick();
    n_checks++;
    if (b_qa !== BIV || b_qb !== BIV)
      $display("FAIL scale_sweep_readback: qa=%h qb=%h expected %h", b_qa, b_qb, BIV);
    else n_pass++;
    b_re = 0;
    $display("test_scale: complete");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dual_read();
    test_collision();
    test_sweep();
    test_back_to_back();
    test_abort();
    test_random();
    test_scale();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
